// File: rtl/pgr_uart_rx_32bit_if.sv
// rtl/pgr_uart_rx_32bit_if.sv - byte stream interface from the UART receiver to the command parser

interface pgr_uart_rx_32bit_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  // Receiver side: produces bytes and status pulses, consumes ready.
  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  // Parser side: consumes bytes and status pulses, produces ready.
  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/pgr_uart_rx_32bit.sv
// rtl/pgr_uart_rx_32bit.sv - 8N1 UART receiver with 6x tick grid, 3-sample mid-bit vote, framing/overrun flags

module pgr_uart_rx_32bit #(
  parameter int OS_RATE = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic                 rxd,
  pgr_uart_rx_32bit_if.master  rx_bus
);

  // Receiver states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  // Positions on the tick grid inside one bit period.
  localparam logic [2:0] TICK_S2   = 3'd2;
  localparam logic [2:0] TICK_S3   = 3'd3;
  localparam logic [2:0] TICK_VOTE = 3'd4;
  localparam logic [2:0] TICK_LAST = 3'(OS_RATE - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic [2:0] r_state;
  logic [2:0] r_tick_cnt;
  logic [2:0] r_bit_cnt;
  logic       r_s2;
  logic       r_s3;
  logic [7:0] r_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_frame_err;
  logic       r_overrun;

  logic       w_rxd_s;
  logic       w_vote;
  logic [2:0] w_tick_next;
  logic       w_vote_tick;
  logic       w_byte_done;
  logic       w_frame_bad;
  logic       w_accept;

  assign w_rxd_s     = r_sync2;
  assign w_vote      = (r_s2 & r_s3) | (r_s2 & w_rxd_s) | (r_s3 & w_rxd_s);
  assign w_tick_next = (r_tick_cnt == TICK_LAST) ? 3'd0 : r_tick_cnt + 3'd1;
  assign w_vote_tick = clk_en && (r_tick_cnt == TICK_VOTE);
  assign w_byte_done = w_vote_tick && (r_state == ST_STOP) && w_vote;
  assign w_frame_bad = w_vote_tick && (r_state == ST_STOP) && !w_vote;
  assign w_accept    = r_rx_valid && rx_bus.rx_ready;

  // Two-flop synchronizer for the asynchronous line; resets to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM with tick and bit counters; only moves on a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_tick_cnt <= 3'd0;
      r_bit_cnt  <= 3'd0;
    end else if (clk_en) begin
      case (r_state)
        ST_IDLE: begin
          // The detect tick itself is tick 0 of the start bit.
          r_tick_cnt <= 3'd0;
          if (!w_rxd_s) begin
            r_state    <= ST_START;
            r_tick_cnt <= 3'd1;
          end
        end
        ST_START: begin
          r_tick_cnt <= w_tick_next;
          if ((r_tick_cnt == TICK_VOTE) && w_vote) begin
            // Start bit did not hold low through mid-bit: treat as a glitch.
            r_state    <= ST_IDLE;
            r_tick_cnt <= 3'd0;
          end else if (r_tick_cnt == TICK_LAST) begin
            r_state   <= ST_DATA;
            r_bit_cnt <= 3'd0;
          end
        end
        ST_DATA: begin
          r_tick_cnt <= w_tick_next;
          if (r_tick_cnt == TICK_LAST) begin
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        ST_STOP: begin
          r_tick_cnt <= w_tick_next;
          if (r_tick_cnt == TICK_VOTE) begin
            // Leave at mid stop bit so a fast transmitter's next start is not missed.
            r_state    <= w_vote ? ST_IDLE : ST_BRK;
            r_tick_cnt <= 3'd0;
          end
        end
        ST_BRK: begin
          // Hold here while the line stays low so a break cannot start a frame.
          r_tick_cnt <= 3'd0;
          if (w_rxd_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_tick_cnt <= 3'd0;
        end
      endcase
    end
  end

  // Capture the two early vote samples of the current bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else if (clk_en && (r_state != ST_IDLE) && (r_state != ST_BRK)) begin
      if (r_tick_cnt == TICK_S2) begin
        r_s2 <= w_rxd_s;
      end
      if (r_tick_cnt == TICK_S3) begin
        r_s3 <= w_rxd_s;
      end
    end
  end

  // Right-shift voted data bits in so the first bit lands in bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= 8'h00;
    end else if (w_vote_tick && (r_state == ST_DATA)) begin
      r_shift <= {w_vote, r_shift[7:1]};
    end
  end

  // Output holding register, handshake and one-clock status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      r_overrun   <= 1'b0;
      if (w_byte_done) begin
        if (!r_rx_valid || w_accept) begin
          // Slot is free or being freed this cycle: new byte replaces it.
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          // Parser still holds the old byte: keep it and drop the new one.
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data   = r_rx_data;
  assign rx_bus.rx_valid  = r_rx_valid;
  assign rx_bus.frame_err = r_frame_err;
  assign rx_bus.overrun   = r_overrun;

endmodule

// File: tb/tb_pgr_uart_rx_32bit.sv
// tb/tb_pgr_uart_rx_32bit.sv - directed self-checking bench for the UART receiver

module tb_pgr_uart_rx_32bit;

  // Time units: clock period 100, tick every 3 clocks, bit = 6 ticks = 1800.
  localparam real CLK_HALF = 50.0;
  localparam real BIT_NOM  = 1800.0;
  localparam real BIT_SLOW = 1854.0;
  localparam real BIT_FAST = 1746.0;
  localparam real SPIKE_W  = 250.0;

  logic clk;
  logic rst_n;
  logic clk_en;
  logic rxd;
  logic [1:0] tick_div;

  pgr_uart_rx_32bit_if u_if ();

  pgr_uart_rx_32bit #(.OS_RATE(6)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .rxd    (rxd),
    .rx_bus (u_if)
  );

  int n_cmp;
  int n_bad;

  logic [7:0] q_rx[$];
  int ferr_cnt;
  int ferr_wide;
  int ovr_cnt;
  int ovr_wide;
  int valid_run;
  int valid_max;
  logic prev_ferr;
  logic prev_ovr;

  initial begin
    clk = 1'b0;
    forever #(CLK_HALF) clk = ~clk;
  end

  // Free-running tick: one clk_en cycle every three clocks.
  initial tick_div = 2'd0;
  always @(posedge clk) begin
    tick_div <= (tick_div == 2'd2) ? 2'd0 : tick_div + 2'd1;
    clk_en   <= (tick_div == 2'd2);
  end

  // Record accepted bytes and status pulse activity away from the active edge.
  always @(negedge clk) begin
    if (u_if.rx_valid && u_if.rx_ready) q_rx.push_back(u_if.rx_data);
    if (u_if.frame_err) ferr_cnt = ferr_cnt + 1;
    if (u_if.frame_err && prev_ferr) ferr_wide = ferr_wide + 1;
    if (u_if.overrun) ovr_cnt = ovr_cnt + 1;
    if (u_if.overrun && prev_ovr) ovr_wide = ovr_wide + 1;
    prev_ferr = u_if.frame_err;
    prev_ovr  = u_if.overrun;
    if (u_if.rx_valid) valid_run = valid_run + 1;
    else valid_run = 0;
    if (valid_run > valid_max) valid_max = valid_run;
  end

  task automatic clear_mon();
    q_rx.delete();
    ferr_cnt  = 0;
    ferr_wide = 0;
    ovr_cnt   = 0;
    ovr_wide  = 0;
    valid_max = 0;
  endtask

  task automatic idle_bits(input real n);
    rxd = 1'b1;
    #(n * BIT_NOM);
  endtask

  // Transmit one 8N1 frame; optional short inverted spike at tick 2 of each data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_val, input real bit_t,
                           input logic spike);
    real pre;
    pre = bit_t * 2.0 / 6.0;
    rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (spike) begin
        #(pre);
        rxd = ~b[i];
        #(SPIKE_W);
        rxd = b[i];
        #(bit_t - pre - SPIKE_W);
      end else begin
        #(bit_t);
      end
    end
    rxd = stop_val;
    #(bit_t);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    u_if.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got=%b exp=0", u_if.rx_valid); end
    n_cmp++; if (u_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got=%h exp=00", u_if.rx_data); end
    n_cmp++; if (u_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got=%b exp=0", u_if.frame_err); end
    n_cmp++; if (u_if.overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got=%b exp=0", u_if.overrun); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_directed_byte();
    u_if.rx_ready = 1'b1;
    clear_mon();
    send_byte(8'hA5, 1'b1, BIT_NOM, 1'b0);
    idle_bits(2.0);
    n_cmp++; if (q_rx.size() !== 1) begin n_bad++; $display("FAIL directed_count got=%0d exp=1", q_rx.size()); end
    if (q_rx.size() > 0) begin
      n_cmp++; if (q_rx[0] !== 8'hA5) begin n_bad++; $display("FAIL directed_data got=%h exp=a5", q_rx[0]); end
    end
    n_cmp++; if (valid_max !== 1) begin n_bad++; $display("FAIL directed_valid_width got=%0d exp=1", valid_max); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL directed_frame_err got=%0d exp=0", ferr_cnt); end
    n_cmp++; if (ovr_cnt !== 0) begin n_bad++; $display("FAIL directed_overrun got=%0d exp=0", ovr_cnt); end
  endtask

  task automatic test_glitch();
    clear_mon();
    // Low for two ticks: gone before the mid-bit vote.
    rxd = 1'b0;
    #(600.0);
    rxd = 1'b1;
    idle_bits(3.0);
    n_cmp++; if (q_rx.size() !== 0) begin n_bad++; $display("FAIL glitch_no_byte got=%0d exp=0", q_rx.size()); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL glitch_frame_err got=%0d exp=0", ferr_cnt); end
    send_byte(8'h3C, 1'b1, BIT_NOM, 1'b0);
    idle_bits(2.0);
    n_cmp++; if (q_rx.size() !== 1) begin n_bad++; $display("FAIL glitch_after_count got=%0d exp=1", q_rx.size()); end
    if (q_rx.size() > 0) begin
      n_cmp++; if (q_rx[0] !== 8'h3C) begin n_bad++; $display("FAIL glitch_after_data got=%h exp=3c", q_rx[0]); end
    end
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_byte(8'h55, 1'b0, BIT_NOM, 1'b0);
    #(3.0 * BIT_NOM);
    idle_bits(2.0);
    n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt); end
    n_cmp++; if (ferr_wide !== 0) begin n_bad++; $display("FAIL ferr_width extra_cycles=%0d exp=0", ferr_wide); end
    n_cmp++; if (q_rx.size() !== 0) begin n_bad++; $display("FAIL ferr_no_byte got=%0d exp=0", q_rx.size()); end
    send_byte(8'h81, 1'b1, BIT_NOM, 1'b0);
    idle_bits(2.0);
    n_cmp++; if (q_rx.size() !== 1) begin n_bad++; $display("FAIL ferr_after_count got=%0d exp=1", q_rx.size()); end
    if (q_rx.size() > 0) begin
      n_cmp++; if (q_rx[0] !== 8'h81) begin n_bad++; $display("FAIL ferr_after_data got=%h exp=81", q_rx[0]); end
    end
    n_cmp++; if (ferr_cnt !== 1) begin n_bad++; $display("FAIL ferr_after_count_err got=%0d exp=1", ferr_cnt); end
  endtask

  task automatic test_overrun();
    clear_mon();
    u_if.rx_ready = 1'b0;
    send_byte(8'h11, 1'b1, BIT_NOM, 1'b0);
    send_byte(8'h22, 1'b1, BIT_NOM, 1'b0);
    idle_bits(1.0);
    @(negedge clk);
    n_cmp++; if (u_if.rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid_held got=%b exp=1", u_if.rx_valid); end
    n_cmp++; if (u_if.rx_data !== 8'h11) begin n_bad++; $display("FAIL ovr_data_kept got=%h exp=11", u_if.rx_data); end
    n_cmp++; if (ovr_cnt !== 1) begin n_bad++; $display("FAIL ovr_count got=%0d exp=1", ovr_cnt); end
    n_cmp++; if (ovr_wide !== 0) begin n_bad++; $display("FAIL ovr_width extra_cycles=%0d exp=0", ovr_wide); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL ovr_frame_err got=%0d exp=0", ferr_cnt); end
    @(posedge clk);
    #2;
    u_if.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_drop got=%b exp=0", u_if.rx_valid); end
    n_cmp++; if (q_rx.size() !== 1) begin n_bad++; $display("FAIL ovr_accept_count got=%0d exp=1", q_rx.size()); end
    idle_bits(1.0);
  endtask

  task automatic test_skew_noise();
    logic [7:0] exp_b;
    clear_mon();
    for (int i = 0; i < 256; i++) begin
      exp_b = 8'(i);
      send_byte(exp_b, 1'b1, (i < 128) ? BIT_SLOW : BIT_FAST, 1'b1);
      idle_bits(1.0);
    end
    idle_bits(1.0);
    n_cmp++; if (q_rx.size() !== 256) begin n_bad++; $display("FAIL skew_count got=%0d exp=256", q_rx.size()); end
    for (int i = 0; i < q_rx.size(); i++) begin
      exp_b = 8'(i);
      n_cmp++; if (q_rx[i] !== exp_b) begin n_bad++; $display("FAIL skew_data idx=%0d got=%h exp=%h", i, q_rx[i], exp_b); end
    end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL skew_frame_err got=%0d exp=0", ferr_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    fork
      begin
        send_byte(8'hF0, 1'b1, BIT_NOM, 1'b0);
      end
      begin
        // Data bit 4 spans 5..6 bit times after the start edge.
        #(5.3 * BIT_NOM);
        rst_n = 1'b0;
        #(400.0);
        n_cmp++; if (u_if.rx_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got=%b exp=0", u_if.rx_valid); end
        n_cmp++; if (u_if.rx_data !== 8'h00) begin n_bad++; $display("FAIL midrst_data got=%h exp=00", u_if.rx_data); end
        n_cmp++; if (u_if.frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err got=%b exp=0", u_if.frame_err); end
        #(400.0);
        rst_n = 1'b1;
      end
    join
    idle_bits(2.0);
    n_cmp++; if (q_rx.size() !== 0) begin n_bad++; $display("FAIL midrst_aborted got=%0d exp=0", q_rx.size()); end
    n_cmp++; if (ferr_cnt !== 0) begin n_bad++; $display("FAIL midrst_ferr got=%0d exp=0", ferr_cnt); end
    send_byte(8'h0F, 1'b1, BIT_NOM, 1'b0);
    idle_bits(2.0);
    n_cmp++; if (q_rx.size() !== 1) begin n_bad++; $display("FAIL midrst_after_count got=%0d exp=1", q_rx.size()); end
    if (q_rx.size() > 0) begin
      n_cmp++; if (q_rx[0] !== 8'h0F) begin n_bad++; $display("FAIL midrst_after_data got=%h exp=0f", q_rx[0]); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    valid_run = 0;
    prev_ferr = 1'b0;
    prev_ovr  = 1'b0;
    clear_mon();
    test_reset();
    test_directed_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_skew_noise();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pgr_uart_rx_32bit.md
# pgr_uart_rx_32bit

UART receive stage for the uart2apb bridge: it consumes the 6x-baud tick from the `pgr_clk_gen_32bit` clock-enable generator and recovers 8N1 bytes from the serial line.
- Each bit is sampled on the tick grid, and the value is decided by a 3-sample majority vote at mid-bit.
- Recovered bytes are presented on a valid/ready interface to the downstream command parser.
- Framing errors and overruns are flagged.

## Interface
Parameters:
- OS_RATE, 6, ticks per bit; fixed to match the clock-enable generator; supported value 6 only.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clk_en  input  1  one-cycle tick, 6 per bit period; FSM and sampling advance only when high.
- rxd  input  1  asynchronous serial line, idle high.
- rx_ready  input  1  downstream accepts byte when rx_valid & rx_ready.
- rx_data  output  8  received byte; LSB received first.
- rx_valid  output  1  byte available; held until accepted.
- frame_err  output  1  one-cycle pulse: stop bit decoded as 0.
- overrun  output  1  one-cycle pulse: a byte completed while rx_valid was still high.

## Operation
- rxd passes through a 2-flop synchronizer (reset value 1) to produce rxd_s; all decisions use rxd_s.
- tick_cnt: 3 bits, range 0..5, advances only on clk_en, wraps 5->0; bit_cnt: 3 bits.
- Within each bit, rxd_s is sampled on ticks 2 and 3.
- On tick 4: vote = majority(s2, s3, rxd_s).
- States:
  - IDLE:
    - On a clk_en cycle with rxd_s==0: go to START, tick_cnt<=1. This detect tick counts as tick 0.
  - START:
    - At tick 4: if vote==1 (glitch), go to IDLE; else continue.
    - At tick 5: go to DATA, bit_cnt<=0.
  - DATA:
    - At tick 4: shift vote into shift register MSB (right shift), so bit 0 ends in rx_data[0].
    - At tick 5: if bit_cnt==7, go to STOP; else bit_cnt++.
  - STOP:
    - At tick 4, vote==1: byte done; go to IDLE immediately. The remaining tick 5 is skipped to absorb transmitter clock skew.
    - At tick 4, vote==0: frame_err pulse, discard byte, go to BRK.
  - BRK: wait for a clk_en cycle with rxd_s==1, then go to IDLE. This prevents a held-low line/break from re-triggering starts.
- Byte done:
  - If rx_valid==0 or (rx_valid & rx_ready) in the same cycle: load rx_data, set rx_valid.
  - Otherwise: keep the old rx_data/rx_valid, pulse overrun, drop the new byte.
- rx_valid clears on a cycle where rx_valid & rx_ready and no new byte loads.
- rx_ready is ignored while rx_valid==0.
- Reset values: all outputs 0, state IDLE, counters 0, shift register 0. Reset mid-frame aborts with no outputs; reception resumes at the next falling edge after release.

## Timing
- Synchronizer latency: 2 clk from rxd to rxd_s.
- rx_valid (or frame_err/overrun) asserts 1 clk after the clk_en cycle that carries stop-bit tick 4, registered.
- From the start-bit detect tick to byte done: 9*6+4 = 58 ticks.
- frame_err and overrun are exactly 1 clk wide regardless of clk_en spacing.
- Acceptance is zero-latency: rx_valid drops the cycle after the handshake.
- Back-to-back frames are supported: after byte done, the next start can be detected on the following tick.
- No behaviour depends on clk between ticks except the handshake and pulse outputs.
- Ticks arriving during any state beyond the defined transitions are ignored.

## Test plan
- Directed byte: CLK_FREQ=50 gives a tick every 72 clk and a bit every 432 clk. Send 0xA5 8N1 with rx_ready=1 -> rx_valid pulses for 1 clk with rx_data=0xA5, frame_err=0, overrun=0.
- Glitch rejection: drive rxd low for 100 clk, then high -> no rx_valid and state returns to IDLE. Then send 0x3C -> rx_data=0x3C.
- Framing error: send 0x55 with stop bit 0, hold low 3 bit times, then idle, then send 0x81 -> frame_err is one 1-clk pulse, no rx_valid for 0x55, and rx_data=0x81 is received afterwards.
- Overrun: rx_ready=0, send 0x11 then 0x22 back-to-back -> rx_valid=1 with rx_data=0x11 and a 1-clk overrun pulse at the second byte. Then raise rx_ready -> rx_valid drops the next cycle.
- Skew and noise: transmitter bit time at +3% and -3% of nominal, plus a 1-tick-wide inverted spike at tick 2 of each data bit. Send 256 incrementing bytes -> all 256 received correctly.
- Reset mid-frame: assert rst_n=0 during data bit 4 of 0xF0, release, then send 0x0F -> no output from the aborted frame, outputs 0 during reset, and rx_data=0x0F received.
